// File: rtl/qspi_resp_pkg.sv
// Shared definitions for the QSPI memory responder: FSM states and bus opcodes.
package qspi_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h02;
  localparam logic [1:0] MODE_CONT  = 2'b10;

endpackage

// File: rtl/qspi_resp_mem.sv
// Byte array behind the responder: combinational read, synchronous write, no reset.
module qspi_resp_mem #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI target for the tinyqv memory bus: decodes quad cmd/addr/mode/dummy phases
// and serves reads from / commits writes to an internal byte array.
module qspi_mem_responder
  import qspi_resp_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CYCLES = 4,
  parameter bit WRITE_EN     = 1'b1,
  parameter bit CONT_READ_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic [3:0] spi_data_in,
  output logic [3:0] spi_data_out,
  output logic [3:0] spi_data_oe
);

  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [3:0]        nib_q, nib_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_wr_q, is_wr_d;
  logic              cont_q, cont_d;
  logic [3:0]        out_q, out_d;
  logic              oe_q, oe_d;
  logic              spi_clk_q;

  logic       rise, fall;
  logic [7:0] byte_in;
  logic       mem_we;
  logic [7:0] mem_rdata;

  assign rise    = spi_clk & ~spi_clk_q;
  assign fall    = ~spi_clk & spi_clk_q;
  assign byte_in = {nib_q, spi_data_in};

  qspi_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .addr_i (addr_q),
    .we_i   (mem_we),
    .wdata_i(byte_in),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      nib_q     <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      cont_q    <= 1'b0;
      out_q     <= '0;
      oe_q      <= 1'b0;
      spi_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      nib_q     <= nib_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      cont_q    <= cont_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      spi_clk_q <= spi_clk;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nib_d   = nib_q;
    addr_d  = addr_q;
    is_wr_d = is_wr_q;
    cont_d  = cont_q;
    out_d   = out_q;
    oe_d    = oe_q;
    mem_we  = 1'b0;

    // Deselect overrides any edge seen in the same cycle; cont_q survives it.
    if (spi_cs_n) begin
      state_d = ST_IDLE;
      phase_d = '0;
      oe_d    = 1'b0;
      out_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          phase_d = '0;
          if (cont_q) begin
            state_d = ST_ADDR;
            is_wr_d = 1'b0;
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_CMD: if (rise) begin
          nib_d   = spi_data_in;
          phase_d = phase_q + 3'd1;
          if (phase_q == 3'd1) begin
            phase_d = '0;
            if (byte_in == CMD_QREAD) begin
              state_d = ST_ADDR;
              is_wr_d = 1'b0;
            end else if (byte_in == CMD_QWRITE && WRITE_EN) begin
              state_d = ST_ADDR;
              is_wr_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: if (rise) begin
          // Upper address nibbles simply shift out of the narrower register.
          addr_d  = {addr_q[ADDR_W-5:0], spi_data_in};
          phase_d = phase_q + 3'd1;
          if (phase_q == 3'd5) begin
            phase_d = '0;
            state_d = is_wr_q ? ST_WDATA : ST_MODE;
          end
        end
        ST_MODE: if (rise) begin
          nib_d   = spi_data_in;
          phase_d = phase_q + 3'd1;
          if (phase_q == 3'd1) begin
            phase_d = '0;
            cont_d  = CONT_READ_EN && (byte_in[5:4] == MODE_CONT);
            state_d = (DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY;
          end
        end
        ST_DUMMY: if (rise) begin
          phase_d = phase_q + 3'd1;
          if (phase_q == DUMMY_LAST) begin
            phase_d = '0;
            state_d = ST_RDATA;
          end
        end
        ST_RDATA: if (fall) begin
          oe_d       = 1'b1;
          phase_d[0] = ~phase_q[0];
          if (!phase_q[0]) begin
            out_d = mem_rdata[7:4];
          end else begin
            out_d  = mem_rdata[3:0];
            addr_d = addr_q + 1'b1;
          end
        end
        ST_WDATA: if (rise) begin
          nib_d   = spi_data_in;
          phase_d = {2'b00, ~phase_q[0]};
          if (phase_q[0]) begin
            mem_we = 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign spi_data_out = out_q;
  assign spi_data_oe  = {4{oe_q}};

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed + randomized bench: a RAM-configured and a flash-configured responder
// driven by a task-level QSPI controller, checked against a byte-map model.
module tb_qspi_mem_responder;

  localparam int AW = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_r_n = 1'b1;
  logic       cs_f_n = 1'b1;
  logic       spi_clk = 1'b0;
  logic [3:0] din = 4'h0;
  logic [3:0] dout_r, oe_r, dout_f, oe_f;

  always #5 clk = ~clk;

  qspi_mem_responder #(.ADDR_W(AW), .DUMMY_CYCLES(4), .WRITE_EN(1'b1), .CONT_READ_EN(1'b1)) dut_r (
    .clk(clk), .rst(rst), .spi_cs_n(cs_r_n), .spi_clk(spi_clk),
    .spi_data_in(din), .spi_data_out(dout_r), .spi_data_oe(oe_r)
  );

  qspi_mem_responder #(.ADDR_W(AW), .DUMMY_CYCLES(4), .WRITE_EN(1'b0), .CONT_READ_EN(1'b1)) dut_f (
    .clk(clk), .rst(rst), .spi_cs_n(cs_f_n), .spi_clk(spi_clk),
    .spi_data_in(din), .spi_data_out(dout_f), .spi_data_oe(oe_f)
  );

  int         tests = 0;
  int         fails = 0;
  bit         tgt_f = 1'b0;
  bit         cont_m [2];
  logic [7:0] mem_m [int];
  logic [7:0] rd_q [$];
  logic [3:0] oe_acc;

  function automatic logic [3:0] cur_out();
    return tgt_f ? dout_f : dout_r;
  endfunction

  function automatic logic [3:0] cur_oe();
    return tgt_f ? oe_f : oe_r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_cyc(input logic [3:0] n, output logic [3:0] d, output logic [3:0] e);
    @(negedge clk) din = n;
    repeat (2) @(negedge clk);
    d = cur_out();
    e = cur_oe();
    spi_clk = 1'b1;
    repeat (2) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    logic [3:0] d, e;
    spi_cyc(n, d, e);
    oe_acc |= e;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic sel();
    @(negedge clk);
    if (tgt_f) cs_f_n = 1'b0;
    else       cs_r_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic desel();
    @(negedge clk);
    cs_r_n = 1'b1;
    cs_f_n = 1'b1;
    repeat (2) @(negedge clk);
    check("deselect_oe", 32'(cur_oe()), 32'h0);
  endtask

  task automatic do_read(input logic [23:0] a, input logic [7:0] mode, input int n);
    logic [3:0] h, l, eh, el;
    rd_q.delete();
    oe_acc = 4'h0;
    sel();
    if (!cont_m[tgt_f]) send_byte(8'hEB);
    send_addr(a);
    send_byte(mode);
    repeat (4) send_nib(4'h0);
    check("ctl_phase_oe", 32'(oe_acc), 32'h0);
    for (int i = 0; i < n; i++) begin
      spi_cyc(4'h0, h, eh);
      spi_cyc(4'h0, l, el);
      rd_q.push_back({h, l});
      check("rdata_oe", 32'({eh, el}), 32'hFF);
    end
    desel();
    cont_m[tgt_f] = (mode[5:4] == 2'b10);
  endtask

  task automatic ram_read_chk(input logic [23:0] a, input logic [7:0] mode, input int n);
    int ea;
    do_read(a, mode, n);
    for (int i = 0; i < n; i++) begin
      ea = (int'(a[AW-1:0]) + i) % (1 << AW);
      check("rdata", 32'(rd_q[i]), 32'(mem_m[ea]));
    end
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] wq [$]);
    if (cont_m[tgt_f]) do_read(a, 8'h00, 1);
    sel();
    oe_acc = 4'h0;
    send_byte(8'h02);
    send_addr(a);
    foreach (wq[i]) send_byte(wq[i]);
    desel();
    if (!tgt_f)
      foreach (wq[i]) mem_m[(int'(a[AW-1:0]) + i) % (1 << AW)] = wq[i];
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wq [$];
    logic [7:0] v, b0, mode;
    logic [23:0] a24;
    logic [3:0] d, e;
    int len;

    cont_m[0] = 1'b0;
    cont_m[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_oe_r", 32'(oe_r), 32'h0);
    check("reset_out_r", 32'(dout_r), 32'h0);
    check("reset_oe_f", 32'(oe_f), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic read of preloaded bytes
    wq = '{8'hA5, 8'h3C};
    do_write(24'h000010, wq);
    ram_read_chk(24'h000010, 8'h00, 2);
    check("read_A5", 32'(rd_q[0]), 32'hA5);
    check("read_3C", 32'(rd_q[1]), 32'h3C);

    // continuous read: second select carries no command
    ram_read_chk(24'h000010, 8'hA0, 1);
    ram_read_chk(24'h000011, 8'h00, 1);
    check("cont_3C", 32'(rd_q[0]), 32'h3C);
    ram_read_chk(24'h000010, 8'h00, 2);

    // write across the top of the array
    wq = '{8'h11, 8'h22};
    do_write(24'h000FFF, wq);
    ram_read_chk(24'h000FFF, 8'h00, 2);
    check("wrap_11", 32'(rd_q[0]), 32'h11);
    check("wrap_22", 32'(rd_q[1]), 32'h22);

    // aborted write after one nibble
    v = 8'($urandom);
    wq = '{v};
    do_write(24'h000020, wq);
    sel();
    send_byte(8'h02);
    send_addr(24'h000020);
    send_nib(4'h7);
    desel();
    ram_read_chk(24'h000020, 8'h00, 1);

    // randomized write/read-back with random mode bytes
    for (int it = 0; it < 8; it++) begin
      a24 = {12'($urandom), 12'($urandom)};
      len = $urandom_range(1, 3);
      wq.delete();
      for (int j = 0; j < len; j++) wq.push_back(8'($urandom));
      do_write(a24, wq);
      mode = 8'($urandom);
      if (it % 3 == 0) mode = {mode[7:6], 2'b10, mode[3:0]};
      ram_read_chk(a24, mode, len);
    end

    // reset mid-RDATA while in continuous mode
    ram_read_chk(24'h000010, 8'hA0, 1);
    sel();
    send_addr(24'h000010);
    send_byte(8'hA0);
    repeat (4) send_nib(4'h0);
    spi_cyc(4'h0, d, e);
    check("pre_reset_nib", 32'({d, e}), 32'hAF);
    @(negedge clk) rst = 1'b1;
    #1;
    check("async_rst_oe", 32'(oe_r), 32'h0);
    check("async_rst_out", 32'(dout_r), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cs_r_n = 1'b1;
    cont_m[0] = 1'b0;
    repeat (2) @(negedge clk);
    ram_read_chk(24'h000010, 8'h00, 2);

    // flash configuration: writes ignored, unknown command ignored
    tgt_f = 1'b1;
    do_read(24'h000000, 8'h00, 1);
    b0 = rd_q[0];
    wq = '{~b0};
    do_write(24'h000000, wq);
    check("flash_wr_oe", 32'(oe_acc), 32'h0);
    do_read(24'h000000, 8'h00, 1);
    check("flash_unchanged", 32'(rd_q[0]), 32'(b0));
    sel();
    oe_acc = 4'h0;
    send_byte(8'h9F);
    send_addr(24'h000000);
    repeat (8) send_nib(4'h0);
    check("flash_ignore_oe", 32'(oe_acc), 32'h0);
    desel();
    do_read(24'h000000, 8'h00, 1);
    check("flash_after_ignore", 32'(rd_q[0]), 32'(b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
